// File: rtl/proc_dmem_responder_if.sv
// Val/rdy request and response streams between the processor (master) and its memory responder (slave).
// Request layout is {rsvd[77], type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}.
interface proc_dmem_responder_if;
  logic        reqstream_val;
  logic        reqstream_rdy;
  logic [77:0] reqstream_msg;
  logic        respstream_val;
  logic        respstream_rdy;
  logic [46:0] respstream_msg;

  modport master (
    output reqstream_val, reqstream_msg, respstream_rdy,
    input  reqstream_rdy, respstream_val, respstream_msg
  );

  modport slave (
    input  reqstream_val, reqstream_msg, respstream_rdy,
    output reqstream_rdy, respstream_val, respstream_msg
  );
endinterface

// File: rtl/proc_dmem_responder.sv
// Word-array memory responder: accepts READ/WRITE/INIT requests and answers them in order
// after a fixed latency, with at most p_resp_depth responses outstanding.
module proc_dmem_responder #(
  parameter int p_mem_words  = 256,
  parameter int p_latency    = 2,
  parameter int p_resp_depth = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  proc_dmem_responder_if.slave              mem,
  output logic                              error,
  output logic [$clog2(p_resp_depth+1)-1:0] num_outstanding
);

  localparam int          IDX_W      = $clog2(p_mem_words);
  localparam int          CNT_W      = $clog2(p_resp_depth + 1);
  localparam int          PTR_W      = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * p_mem_words);
  localparam logic [2:0]  T_READ     = 3'd0;
  localparam logic [2:0]  T_INIT     = 3'd2;

  logic             unused_rsvd;
  logic [2:0]       req_type;
  logic [7:0]       req_opq;
  logic [31:0]      req_addr;
  logic [1:0]       req_len;
  logic [31:0]      req_data;
  logic [IDX_W-1:0] idx;
  logic             fire_req, fire_resp, req_err, req_wr;
  logic [31:0]      resp_data;
  logic [46:0]      new_msg;
  logic             push_val;
  logic [46:0]      push_msg;
  logic             resp_val;

  logic             released_q;
  logic             error_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]      mem_q  [p_mem_words];
  logic [46:0]      fifo_q [p_resp_depth];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(p_resp_depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign {unused_rsvd, req_type, req_opq, req_addr, req_len, req_data} = mem.reqstream_msg;

  assign mem.reqstream_rdy = released_q && (cnt_q < CNT_W'(p_resp_depth));
  assign fire_req  = mem.reqstream_val && mem.reqstream_rdy;
  assign resp_val  = (fill_q != '0);
  assign fire_resp = resp_val && mem.respstream_rdy;

  assign idx       = req_addr[IDX_W+1:2];
  assign req_err   = (req_type > T_INIT) || (req_len != 2'd0) || (req_addr >= ADDR_LIMIT);
  assign req_wr    = fire_req && !req_err && (req_type != T_READ);
  assign resp_data = (!req_err && req_type == T_READ) ? mem_q[idx] : '0;
  assign new_msg   = {req_type, req_opq, 2'b00, 2'b00, resp_data};

  // Array is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (req_wr) mem_q[idx] <= req_data;
  end

  // The response FIFO adds one register stage, so the pipe holds p_latency-1 stages.
  if (p_latency == 1) begin : g_no_pipe
    assign push_val = fire_req;
    assign push_msg = new_msg;
  end else begin : g_pipe
    localparam int STG = p_latency - 1;
    logic [STG-1:0] val_q;
    logic [46:0]    msg_q [STG];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        val_q <= '0;
        for (int i = 0; i < STG; i++) msg_q[i] <= '0;
      end else begin
        val_q[0] <= fire_req;
        msg_q[0] <= new_msg;
        for (int i = 1; i < STG; i++) begin
          val_q[i] <= val_q[i-1];
          msg_q[i] <= msg_q[i-1];
        end
      end
    end

    assign push_val = val_q[STG-1];
    assign push_msg = msg_q[STG-1];
  end

  always_comb begin
    cnt_d  = cnt_q;
    fill_d = fill_q;
    case ({fire_req, fire_resp})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({push_val, fire_resp})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      released_q <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      fill_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      released_q <= 1'b1;
      error_q    <= error_q || (fire_req && req_err);
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      if (push_val)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fire_resp) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push_val) fifo_q[wr_ptr_q] <= push_msg;
  end

  // Gate with valid so the stale head never leaks out after reset.
  assign mem.respstream_val = resp_val;
  assign mem.respstream_msg = resp_val ? fifo_q[rd_ptr_q] : '0;
  assign error              = error_q;
  assign num_outstanding    = cnt_q;

endmodule
